// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the fetch PC, issues one outstanding imem
// request at a time and buffers the returned instruction for decode.
module fetch_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] PC_Next_i,
   input  logic             Redirect_i,
   output logic [WIDTH-1:0] PC_o,
   output logic             Imem_Req_o,
   output logic [WIDTH-1:0] Imem_Addr_o,
   input  logic             Imem_Ready_i,
   input  logic             Imem_Valid_i,
   input  logic [WIDTH-1:0] Imem_Rdata_i,
   output logic             Instr_Valid_o,
   input  logic             Instr_Ready_i,
   output logic [WIDTH-1:0] Instr_o,
   output logic [WIDTH-1:0] Instr_PC_o
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] REQ   = 3'd1;
   localparam logic [2:0] WAIT  = 3'd2;
   localparam logic [2:0] DRAIN = 3'd3;
   localparam logic [2:0] FULL  = 3'd4;

   logic [2:0] state;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         PC_o       <= RESET_PC;
         Instr_o    <= '0;
         Instr_PC_o <= '0;
      end else begin
         if (Redirect_i)
            PC_o <= PC_Next_i;
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               // an accepted request that coincides with a redirect is wrong-path
               if (Imem_Ready_i)
                  state <= Redirect_i ? DRAIN : WAIT;
            end
            WAIT: begin
               if (Imem_Valid_i) begin
                  if (Redirect_i) begin
                     state <= REQ;
                  end else begin
                     Instr_o    <= Imem_Rdata_i;
                     Instr_PC_o <= PC_o;
                     PC_o       <= PC_Next_i;
                     state      <= FULL;
                  end
               end else if (Redirect_i) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (Imem_Valid_i)
                  state <= REQ;
            end
            FULL: begin
               // redirect drops the buffer even if decode is accepting it
               if (Redirect_i || Instr_Ready_i)
                  state <= REQ;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign Imem_Req_o    = (state == REQ);
   assign Instr_Valid_o = (state == FULL);
   assign Imem_Addr_o   = {PC_o[WIDTH-1:2], 2'b00};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, redirects in FULL/WAIT/REQ,
// memory and decode back-pressure, mid-operation reset and unaligned target.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [31:0] PC_Next_i;
   logic        Redirect_i;
   logic [31:0] PC_o;
   logic        Imem_Req_o;
   logic [31:0] Imem_Addr_o;
   logic        Imem_Ready_i;
   logic        Imem_Valid_i;
   logic [31:0] Imem_Rdata_i;
   logic        Instr_Valid_o;
   logic        Instr_Ready_i;
   logic [31:0] Instr_o;
   logic [31:0] Instr_PC_o;

   logic [31:0] tgt;
   int          lat;
   int          total = 0;
   int          bad   = 0;

   fetch_unit #(.WIDTH(32), .RESET_PC(32'h100)) dut (
      .clk_i(clk), .rst_i(rst_i), .PC_Next_i(PC_Next_i), .Redirect_i(Redirect_i),
      .PC_o(PC_o), .Imem_Req_o(Imem_Req_o), .Imem_Addr_o(Imem_Addr_o),
      .Imem_Ready_i(Imem_Ready_i), .Imem_Valid_i(Imem_Valid_i),
      .Imem_Rdata_i(Imem_Rdata_i), .Instr_Valid_o(Instr_Valid_o),
      .Instr_Ready_i(Instr_Ready_i), .Instr_o(Instr_o), .Instr_PC_o(Instr_PC_o)
   );

   always #5 clk = ~clk;

   // next-PC source: sequential +4 unless redirecting
   assign PC_Next_i = Redirect_i ? tgt : PC_o + 32'd4;

   // memory model: fixed latency, word = C0DE_0000 | address, reset with the DUT
   logic        pend;
   int          cnt;
   logic [31:0] paddr;
   always @(posedge clk) begin
      if (rst_i) begin
         pend         <= 1'b0;
         Imem_Valid_i <= 1'b0;
         Imem_Rdata_i <= '0;
         cnt          <= 0;
         paddr        <= '0;
      end else begin
         Imem_Valid_i <= 1'b0;
         if (pend) begin
            if (cnt == 1) begin
               Imem_Valid_i <= 1'b1;
               Imem_Rdata_i <= 32'hC0DE_0000 | paddr;
               pend         <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end
         if (Imem_Req_o && Imem_Ready_i) begin
            if (lat == 1) begin
               Imem_Valid_i <= 1'b1;
               Imem_Rdata_i <= 32'hC0DE_0000 | Imem_Addr_o;
            end else begin
               pend  <= 1'b1;
               cnt   <= lat - 1;
               paddr <= Imem_Addr_o;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      rst_i = 1'b1; Redirect_i = 1'b0; tgt = '0; lat = 1;
      Imem_Ready_i = 1'b1; Instr_Ready_i = 1'b1;
      step();                                   // E0 reset
      chk("rst_pc", PC_o, 32'h100);
      chk("rst_req", {31'd0, Imem_Req_o}, 0);
      chk("rst_vld", {31'd0, Instr_Valid_o}, 0);
      chk("rst_instr", Instr_o, 0);
      chk("rst_ipc", Instr_PC_o, 0);
      rst_i = 1'b0;

      // sequential fetch, one instruction per 3 cycles
      for (int i = 0; i < 3; i++) begin
         step();
         chk("seq_req", {31'd0, Imem_Req_o}, 1);
         chk("seq_addr", Imem_Addr_o, 32'h100 + 32'(4 * i));
         step();
         chk("seq_wait_req", {31'd0, Imem_Req_o}, 0);
         chk("seq_wait_vld", {31'd0, Instr_Valid_o}, 0);
         step();
         chk("seq_vld", {31'd0, Instr_Valid_o}, 1);
         chk("seq_ipc", Instr_PC_o, 32'h100 + 32'(4 * i));
         chk("seq_instr", Instr_o, 32'hC0DE_0100 + 32'(4 * i));
         chk("seq_pc", PC_o, 32'h104 + 32'(4 * i));
      end

      // redirect in FULL while decode is ready: buffer dropped
      Redirect_i = 1'b1; tgt = 32'h200;
      step();                                   // E10
      Redirect_i = 1'b0;
      chk("rfull_vld", {31'd0, Instr_Valid_o}, 0);
      chk("rfull_req", {31'd0, Imem_Req_o}, 1);
      chk("rfull_addr", Imem_Addr_o, 32'h200);

      // redirect in WAIT, response 3 cycles after acceptance
      lat = 3;
      step();                                   // E11 accepted 0x200
      Redirect_i = 1'b1; tgt = 32'h300;
      step();                                   // E12 -> DRAIN
      Redirect_i = 1'b0;
      chk("rwait_pc", PC_o, 32'h300);
      chk("rwait_req", {31'd0, Imem_Req_o}, 0);
      step();                                   // E13 still draining
      chk("drain_req", {31'd0, Imem_Req_o}, 0);
      chk("drain_vld", {31'd0, Instr_Valid_o}, 0);
      step();                                   // E14 stale word dropped
      lat = 1;
      chk("drain_out_req", {31'd0, Imem_Req_o}, 1);
      chk("drain_out_addr", Imem_Addr_o, 32'h300);
      chk("drain_ipc_kept", Instr_PC_o, 32'h108);
      step();                                   // E15
      step();                                   // E16
      chk("r300_vld", {31'd0, Instr_Valid_o}, 1);
      chk("r300_ipc", Instr_PC_o, 32'h300);
      chk("r300_instr", Instr_o, 32'hC0DE_0300);

      // memory back-pressure for 4 cycles, redirect in the second
      step();                                   // E17 REQ 0x304
      Imem_Ready_i = 1'b0;
      step();                                   // E18
      chk("bp_req", {31'd0, Imem_Req_o}, 1);
      chk("bp_addr", Imem_Addr_o, 32'h304);
      chk("bp_pc", PC_o, 32'h304);
      Redirect_i = 1'b1; tgt = 32'h400;
      step();                                   // E19
      Redirect_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_redir_req", {31'd0, Imem_Req_o}, 1);
         chk("bp_redir_addr", Imem_Addr_o, 32'h400);
         if (i < 2) step();
      end
      Imem_Ready_i = 1'b1;
      step();                                   // E22 accepted 0x400
      Instr_Ready_i = 1'b0;
      step();                                   // E23 FULL
      chk("stall_pc", PC_o, 32'h404);

      // decode stall for 5 cycles
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_vld", {31'd0, Instr_Valid_o}, 1);
         chk("stall_ipc", Instr_PC_o, 32'h400);
         chk("stall_instr", Instr_o, 32'hC0DE_0400);
         chk("stall_req", {31'd0, Imem_Req_o}, 0);
      end
      Instr_Ready_i = 1'b1;
      step();                                   // E29
      chk("unstall_req", {31'd0, Imem_Req_o}, 1);
      chk("unstall_addr", Imem_Addr_o, 32'h404);
      step();                                   // E30 WAIT outstanding

      // reset while a fetch is outstanding
      rst_i = 1'b1;
      step();                                   // E31
      rst_i = 1'b0;
      chk("mrst_pc", PC_o, 32'h100);
      chk("mrst_vld", {31'd0, Instr_Valid_o}, 0);
      chk("mrst_req", {31'd0, Imem_Req_o}, 0);
      step();                                   // E32
      chk("mrst_req2", {31'd0, Imem_Req_o}, 1);
      chk("mrst_addr", Imem_Addr_o, 32'h100);

      // unaligned target while request is not accepted
      Imem_Ready_i = 1'b0; Redirect_i = 1'b1; tgt = 32'h203;
      step();                                   // E33
      Redirect_i = 1'b0; Imem_Ready_i = 1'b1;
      chk("ua_req", {31'd0, Imem_Req_o}, 1);
      chk("ua_addr", Imem_Addr_o, 32'h200);
      chk("ua_pc", PC_o, 32'h203);
      step();                                   // E34
      step();                                   // E35
      chk("ua_vld", {31'd0, Instr_Valid_o}, 1);
      chk("ua_ipc", Instr_PC_o, 32'h203);
      chk("ua_instr", Instr_o, 32'hC0DE_0200);
      chk("ua_pc_next", PC_o, 32'h207);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
